lsu_bus_master: RTL and testbench

- Initiator (master) end of the core's simple SRAM-style memory bus. Sits between the EXU/LSU pipeline stage and the memory slave.
- Accepts one load or store per request from the pipeline.
- Converts byte, half and word accesses into word-aligned bus transactions with write masks.
- Drives the bus address/valid/ready handshake, then returns load data to the pipeline, shifted and sign- or zero-extended.

---
 rtl/lsu_bus_master_pkg.sv | 17 +
 rtl/lsu_bus_master_if.sv | 29 ++
 rtl/lsu_bus_master_lane_align.sv | 45 ++++
 rtl/lsu_bus_master.sv | 143 ++++++++++++++
 tb/tb_lsu_bus_master.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the LSU bus master: access-size encodings, FSM states
// and the byte-lane count of the 32-bit data bus.
package lsu_bus_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_bus_master_if.sv
// SRAM-style memory bus between the LSU master and a memory slave.
interface lsu_bus_master_if
    import lsu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] addr;
    logic              arvalid;
    logic              arready;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  wmask;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    modport master (
        output addr, arvalid, wen, wdata, wmask, rready,
        input  arready, rdata, rvalid
    );

    modport slave (
        input  addr, arvalid, wen, wdata, wmask, rready,
        output arready, rdata, rvalid
    );

endinterface

// File: rtl/lsu_bus_master_lane_align.sv
// Combinational byte-lane alignment: store mask/data replication and load
// shift with sign/zero extension. Shared with the IFU.
module lsu_lane_align
    import lsu_bus_pkg::*;
(
    input  logic [1:0]       i_size,
    input  logic [1:0]       i_off,
    input  logic [31:0]      i_wdata,
    input  logic [31:0]      i_rdata,
    input  logic             i_unsigned,
    output logic [LANES-1:0] o_wmask,
    output logic [31:0]      o_wdata,
    output logic [31:0]      o_rdata
);

    logic [15:0] w_sh;

    // Half accesses ignore off[0]; word and reserved sizes ignore the offset.
    always_comb begin
        o_wmask = '0;
        o_wdata = '0;
        o_rdata = '0;
        w_sh    = '0;
        case (i_size)
            SIZE_B: begin
                o_wmask = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
                w_sh    = 16'(i_rdata >> {i_off, 3'b000});
                o_rdata = {{24{~i_unsigned & w_sh[7]}}, w_sh[7:0]};
            end
            SIZE_H: begin
                o_wmask = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                w_sh    = 16'(i_rdata >> {i_off[1], 4'b0000});
                o_rdata = {{16{~i_unsigned & w_sh[15]}}, w_sh};
            end
            default: begin
                o_wmask = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: one load/store at a time onto the SRAM-style bus.
// Optional LSU_MISALIGN_CHECK_EN reports misaligned half/word accesses as errors.
module lsu_bus_master
    import lsu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wen,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    lsu_bus_master_if.master  bus
);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_wdata;
    logic [LANES-1:0]  r_wmask;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic [LANES-1:0]  w_wmask;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_loadData;

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_err;
    logic w_misalign;
    assign w_misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

    // The aligner sees the live request in IDLE and the latched one afterwards.
    assign w_size = (r_state == IDLE) ? req_size       : r_size;
    assign w_off  = (r_state == IDLE) ? req_addr[1:0]  : r_off;

    lsu_lane_align u_align (
        .i_size     (w_size),
        .i_off      (w_off),
        .i_wdata    (req_wdata),
        .i_rdata    (bus.rdata),
        .i_unsigned (r_unsigned),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_loadData)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_CHECK_EN
                    w_nextState = w_misalign ? RESP : BUS;
`else
                    w_nextState = BUS;
`endif
                end
            end
            BUS:     if (bus.rvalid) w_nextState = RESP;
            RESP:    if (resp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wen      <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_wen      <= req_wen;
                        r_size     <= req_size;
                        r_off      <= req_addr[1:0];
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wen ? w_wdata : '0;
                        r_wmask    <= req_wen ? w_wmask : '0;
                        r_rdata    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                        r_err      <= w_misalign;
`endif
                    end
                end
                BUS: begin
                    if (bus.rvalid) r_rdata <= r_wen ? '0 : w_loadData;
                end
                default: ;
            endcase
        end
    end

    // Bus outputs are forced to zero outside BUS so nothing stale leaks out.
    always_comb begin
        req_ready   = (r_state == IDLE);
        bus.arvalid = (r_state == BUS);
        bus.rready  = (r_state == BUS);
        bus.addr    = (r_state == BUS) ? r_addr  : '0;
        bus.wen     = (r_state == BUS) ? r_wen   : 1'b0;
        bus.wdata   = (r_state == BUS) ? r_wdata : '0;
        bus.wmask   = (r_state == BUS) ? r_wmask : '0;
        resp_valid  = (r_state == RESP);
        resp_rdata  = (r_state == RESP) ? r_rdata : '0;
`ifdef LSU_MISALIGN_CHECK_EN
        resp_err    = (r_state == RESP) ? r_err : 1'b0;
`else
        resp_err    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed accesses against a 3-cycle
// SRAM slave model, with a per-cycle compare against a transaction-level model.
module tb_lsu_bus_master;
    import lsu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    lsu_bus_master_if bus ();

    lsu_bus_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Slave: rvalid on the third cycle of a held arvalid.
    int          slvCnt      = 0;
    int          busWrites   = 0;
    logic [31:0] slaveRdata  = '0;
    logic        strayRvalid = 1'b0;

    assign bus.rvalid  = (bus.arvalid && slvCnt == 2) || strayRvalid;
    assign bus.arready = bus.arvalid && slvCnt == 0;
    assign bus.rdata   = slaveRdata;

    always @(posedge clk) begin
        if (rst) slvCnt <= 0;
        else begin
            if (bus.arvalid && !bus.rvalid) slvCnt <= slvCnt + 1;
            else                            slvCnt <= 0;
            if (bus.rvalid && bus.rready && bus.wen) busWrites <= busWrites + 1;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } expT;

    expT expQ[$];

    function automatic expT makeExp(logic [31:0] a, logic w, logic [31:0] wd,
                                    logic [1:0] sz, logic u, logic [31:0] rd);
        expT    e;
        int     off;
        int     size;
        longint v;
        off     = int'(a[1:0]);
        size    = (sz == 2'b11) ? 2 : int'(sz);
        e.addr  = a & 32'hFFFF_FFFC;
        e.wen   = w;
        e.mask  = '0;
        e.wdata = '0;
        e.rdata = '0;
        e.err   = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((size == 1 && (off % 2) != 0) || (size == 2 && off != 0)) begin
            e.err = 1'b1;
            return e;
        end
`endif
        if (w) begin
            case (size)
                0:       begin e.mask = 4'(1 << off);           e.wdata = wd[7:0]  * 32'h0101_0101; end
                1:       begin e.mask = 4'(3 << ((off / 2) * 2)); e.wdata = wd[15:0] * 32'h0001_0001; end
                default: begin e.mask = 4'hF;                   e.wdata = wd; end
            endcase
        end else begin
            case (size)
                0: begin
                    v = (longint'(rd) >> (8 * off)) & 255;
                    if (!u && v >= 128) v = v - 256;
                    e.rdata = 32'(v);
                end
                1: begin
                    v = (longint'(rd) >> (16 * (off / 2))) & 65535;
                    if (!u && v >= 32768) v = v - 65536;
                    e.rdata = 32'(v);
                end
                default: e.rdata = rd;
            endcase
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        checks++;
        failures++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Per-cycle comparison of bus and response outputs against the model head.
    always @(negedge clk) begin
        if (rst) expQ.delete();
        else begin
            if (bus.arvalid || resp_valid) checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
            if (bus.arvalid) begin
                if (expQ.size() == 0 || expQ[0].err)
                    failNow("unexpected_arvalid", "got arvalid=1 required 0");
                else begin
                    checkOutput("bus_addr",  bus.addr,          expQ[0].addr);
                    checkOutput("bus_wen",   32'(bus.wen),      32'(expQ[0].wen));
                    checkOutput("bus_wmask", 32'(bus.wmask),    32'(expQ[0].mask));
                    checkOutput("bus_wdata", bus.wdata,         expQ[0].wdata);
                    checkOutput("bus_rready", 32'(bus.rready),  32'd1);
                end
            end
            if (resp_valid) begin
                if (expQ.size() == 0)
                    failNow("unexpected_resp", "got resp_valid=1 required 0");
                else begin
                    checkOutput("resp_rdata", resp_rdata,       expQ[0].rdata);
                    checkOutput("resp_err",   32'(resp_err),    32'(expQ[0].err));
                    if (resp_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    // Issues one access from an idle DUT and waits for its response.
    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                 input logic [1:0] sz, input logic u, input logic [31:0] rd,
                                 output logic [31:0] got, output int lat, output int arCyc,
                                 output logic [31:0] bAddr, output logic [3:0] bMask,
                                 output logic [31:0] bData, output logic gotErr);
        bit done = 0;
        slaveRdata = rd;
        expQ.push_back(makeExp(a, w, wd, sz, u, rd));
        req_addr = a; req_wen = w; req_wdata = wd; req_size = sz; req_unsigned = u;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        got = '0; lat = 0; arCyc = 0; bAddr = '0; bMask = '0; bData = '0; gotErr = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (bus.arvalid) begin
                if (arCyc == 0) begin bAddr = bus.addr; bMask = bus.wmask; bData = bus.wdata; end
                arCyc++;
            end
            if (resp_valid) begin got = resp_rdata; gotErr = resp_err; lat = c; done = 1; end
        end
        if (!done) failNow("timeout", "got no resp_valid in 20 cycles required response");
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        failNow("watchdog", "got simulation still running required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] got, bA, bD;
        logic [3:0]  bM;
        logic        gErr;
        int          lat, arc, wBefore;
        bit          seen;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready",  32'(req_ready),  32'd1);
        checkOutput("reset_arvalid",    32'(bus.arvalid), 32'd0);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_wmask",      32'(bus.wmask),  32'd0);
        @(posedge clk); #1;

        $display("[TB] LW aligned");
        applyStimulus(32'h8000_0004, 1'b0, 32'h0, SIZE_W, 1'b0, 32'hDEAD_BEEF, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("lw_addr",     bA,        32'h8000_0004);
        checkOutput("lw_wmask",    32'(bM),   32'd0);
        checkOutput("lw_rdata",    got,       32'hDEAD_BEEF);
        checkOutput("lw_latency",  32'(lat),  32'd4);
        checkOutput("lw_arcycles", 32'(arc),  32'd3);

        $display("[TB] LB / LBU");
        applyStimulus(32'h8000_0003, 1'b0, 32'h0, SIZE_B, 1'b0, 32'h8011_2233, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("lb_rdata",  got, 32'hFFFF_FF80);
        applyStimulus(32'h8000_0003, 1'b0, 32'h0, SIZE_B, 1'b1, 32'h8011_2233, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("lbu_rdata", got, 32'h0000_0080);

        $display("[TB] LH / LHU");
        applyStimulus(32'h8000_0002, 1'b0, 32'h0, SIZE_H, 1'b0, 32'h8001_7FFF, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("lh_rdata",  got, 32'hFFFF_8001);
        applyStimulus(32'h8000_0002, 1'b0, 32'h0, SIZE_H, 1'b1, 32'h8001_7FFF, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("lhu_rdata", got, 32'h0000_8001);

        $display("[TB] SH / SB / SW reserved size");
        wBefore = busWrites;
        applyStimulus(32'h8000_0002, 1'b1, 32'h0000_ABCD, SIZE_H, 1'b0, 32'h5555_5555, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("sh_addr",   bA,      32'h8000_0000);
        checkOutput("sh_wmask",  32'(bM), 32'h0000_000C);
        checkOutput("sh_wdata",  bD,      32'hABCD_ABCD);
        checkOutput("sh_rdata",  got,     32'h0);
        checkOutput("sh_writes", 32'(busWrites - wBefore), 32'd1);
        applyStimulus(32'h8000_0001, 1'b1, 32'h1234_5678, SIZE_B, 1'b0, 32'h0, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("sb_wmask",  32'(bM), 32'h0000_0002);
        checkOutput("sb_wdata",  bD,      32'h7878_7878);
        applyStimulus(32'h8000_0008, 1'b1, 32'h0102_0304, 2'b11, 1'b0, 32'h0, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("sw11_wmask", 32'(bM), 32'h0000_000F);
        checkOutput("sw11_wdata", bD,      32'h0102_0304);

        $display("[TB] misaligned LW");
        applyStimulus(32'h8000_0002, 1'b0, 32'h0, SIZE_W, 1'b0, 32'hCAFE_1234, got, lat, arc, bA, bM, bD, gErr);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("mis_arcycles", 32'(arc),  32'd0);
        checkOutput("mis_latency",  32'(lat),  32'd1);
        checkOutput("mis_err",      32'(gErr), 32'd1);
        checkOutput("mis_rdata",    got,       32'h0);
`else
        checkOutput("mis_addr",     bA,        32'h8000_0000);
        checkOutput("mis_rdata",    got,       32'hCAFE_1234);
        checkOutput("mis_err",      32'(gErr), 32'd0);
`endif

        $display("[TB] back-to-back with stalled response");
        wBefore    = busWrites;
        slaveRdata = 32'h1122_3344;
        expQ.push_back(makeExp(32'h8000_0010, 1'b1, 32'hCAFE_F00D, SIZE_W, 1'b0, 32'h1122_3344));
        expQ.push_back(makeExp(32'h8000_0014, 1'b0, 32'h0,         SIZE_W, 1'b0, 32'h1122_3344));
        resp_ready = 1'b0;
        req_addr = 32'h8000_0010; req_wen = 1'b1; req_wdata = 32'hCAFE_F00D; req_size = SIZE_W; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h8000_0014; req_wen = 1'b0; req_wdata = 32'h0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        if (!seen) failNow("b2b_first_resp", "got no resp_valid required response");
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            checkOutput("b2b_stall_req_ready", 32'(req_ready),   32'd0);
            checkOutput("b2b_stall_arvalid",   32'(bus.arvalid), 32'd0);
            checkOutput("b2b_stall_resp",      32'(resp_valid),  32'd1);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (req_ready) seen = 1;
        end
        if (!seen) failNow("b2b_second_accept", "got req_ready=0 required 1");
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1; got = resp_rdata; end
        end
        if (!seen) failNow("b2b_second_resp", "got no resp_valid required response");
        else checkOutput("b2b_second_rdata", got, 32'h1122_3344);
        @(posedge clk); #1;
        checkOutput("b2b_writes", 32'(busWrites - wBefore), 32'd1);

        $display("[TB] stray rvalid in IDLE");
        strayRvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("stray_resp_valid", 32'(resp_valid),  32'd0);
            checkOutput("stray_req_ready",  32'(req_ready),   32'd1);
        end
        @(posedge clk); #1 strayRvalid = 1'b0;

        $display("[TB] reset during BUS");
        expQ.push_back(makeExp(32'h8000_0018, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h7777_7777));
        slaveRdata = 32'h7777_7777;
        req_addr = 32'h8000_0018; req_wen = 1'b0; req_size = SIZE_W; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_arvalid", 32'(bus.arvalid), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_arvalid",    32'(bus.arvalid), 32'd0);
        checkOutput("rst_rready",     32'(bus.rready),  32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid),  32'd0);
        checkOutput("rst_req_ready",  32'(req_ready),   32'd1);
        @(posedge clk); #1;
        applyStimulus(32'h8000_0020, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0BAD_F00D, got, lat, arc, bA, bM, bD, gErr);
        checkOutput("post_rst_rdata",   got,      32'h0BAD_F00D);
        checkOutput("post_rst_latency", 32'(lat), 32'd4);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
